// File: rtl/fighting_pkg.sv
// Shared definitions for the joystick front end: XADC aux-channel addresses,
// scheduler state encoding and slot helpers.
package fighting_pkg;

   localparam logic [6:0] XADC_ADDR_AUX6  = 7'h16;
   localparam logic [6:0] XADC_ADDR_AUX14 = 7'h1E;
   localparam logic [6:0] XADC_ADDR_AUX7  = 7'h17;
   localparam logic [6:0] XADC_ADDR_AUX15 = 7'h1F;

   typedef logic [1:0] slot_t;

   typedef enum logic [1:0] {
      WAIT_EOC,
      REQ,
      WAIT_DRDY,
      SETTLE
   } sched_state_t;

   // Mid-scale code of a SAMPLE_BITS-wide sample is the stick's rest position.
   function automatic logic [15:0] joy_neutral(input int bits);
      return 16'(1) << (bits - 1);
   endfunction

   function automatic logic [6:0] slot_addr(input slot_t s);
      case (s)
         2'd0:    return XADC_ADDR_AUX6;
         2'd1:    return XADC_ADDR_AUX14;
         2'd2:    return XADC_ADDR_AUX7;
         default: return XADC_ADDR_AUX15;
      endcase
   endfunction

endpackage

// File: rtl/xadc_joystick_scheduler.sv
// XADC DRP owner: one den/drdy read per eoc, round-robin over the four joystick
// aux channels, with a drdy timeout and a settle gap between slots.
module xadc_joystick_scheduler
   import fighting_pkg::*;
#(
   parameter int SAMPLE_BITS    = 4,
   parameter int SETTLE_CYCLES  = 1000,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   input  logic                   eoc,
   input  logic                   drdy,
   input  logic [15:0]            do_data,
   output logic                   den,
   output logic [6:0]             daddr,
   output logic [SAMPLE_BITS-1:0] lee_x,
   output logic [SAMPLE_BITS-1:0] lee_y,
   output logic [SAMPLE_BITS-1:0] king_x,
   output logic [SAMPLE_BITS-1:0] king_y,
   output logic                   sweep_done,
   output logic                   timeout_err,
   output logic                   busy
);

   localparam int TO_W = $clog2((TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES : 2) + 1;
   localparam int ST_W = $clog2((SETTLE_CYCLES > 2) ? SETTLE_CYCLES : 2) + 1;
   localparam logic [TO_W-1:0] TIMEOUT_LAST =
      (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
   // A zero settle time exits on the first SETTLE cycle, same as SETTLE_CYCLES=1.
   localparam logic [ST_W-1:0] SETTLE_LAST =
      (SETTLE_CYCLES > 0) ? ST_W'(SETTLE_CYCLES - 1) : '0;
   localparam logic [SAMPLE_BITS-1:0] JOY_NEUTRAL = SAMPLE_BITS'(joy_neutral(SAMPLE_BITS));

   sched_state_t           state, state_next;
   slot_t                  slot;
   logic [TO_W-1:0]        to_cnt;
   logic [ST_W-1:0]        st_cnt;
   logic [SAMPLE_BITS-1:0] sample [4];
   logic                   capture, expire, settle_exit;
   logic                   unused_low_bits;

   assign unused_low_bits = ^do_data[15-SAMPLE_BITS:0];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= WAIT_EOC;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      capture     = 1'b0;
      expire      = 1'b0;
      settle_exit = 1'b0;
      case (state)
         WAIT_EOC:  if (run && eoc) state_next = REQ;
         REQ:       state_next = WAIT_DRDY;
         WAIT_DRDY: begin
            // drdy takes priority over expiry in the same cycle
            if (drdy) begin
               capture    = 1'b1;
               state_next = SETTLE;
            end else if (to_cnt == TIMEOUT_LAST) begin
               expire     = 1'b1;
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (st_cnt == SETTLE_LAST) begin
               settle_exit = 1'b1;
               state_next  = WAIT_EOC;
            end
         end
         default: state_next = WAIT_EOC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         den         <= 1'b0;
         daddr       <= XADC_ADDR_AUX6;
         slot        <= 2'd0;
         to_cnt      <= '0;
         st_cnt      <= '0;
         sweep_done  <= 1'b0;
         timeout_err <= 1'b0;
         for (int i = 0; i < 4; i++) sample[i] <= JOY_NEUTRAL;
      end else begin
         den        <= (state_next == REQ);
         sweep_done <= 1'b0;
         if (state == REQ) begin
            daddr  <= slot_addr(slot);
            to_cnt <= '0;
         end
         if (state == WAIT_DRDY && !capture && !expire) to_cnt <= to_cnt + TO_W'(1);
         if (capture) sample[slot] <= do_data[15 -: SAMPLE_BITS];
         if (expire)  timeout_err  <= 1'b1;
         st_cnt <= (state == SETTLE) ? st_cnt + ST_W'(1) : '0;
         if (settle_exit) begin
            slot       <= slot + 2'd1;
            daddr      <= slot_addr(slot + 2'd1);
            sweep_done <= (slot == 2'd3);
         end
      end
   end

   assign lee_x  = sample[0];
   assign lee_y  = sample[1];
   assign king_x = sample[2];
   assign king_y = sample[3];
   assign busy   = (state == REQ) || (state == WAIT_DRDY);

endmodule

// File: tb/tb_xadc_joystick_scheduler.sv
// Scoreboard bench for xadc_joystick_scheduler: directed scenarios plus random
// drdy timing, checked against a slot/sample model of the scheduler.
module tb_xadc_joystick_scheduler;

   localparam int SB = 4;
   localparam int ST = 4;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        eoc = 1'b0;
   logic        drdy = 1'b0;
   logic [15:0] do_data = 16'h0;
   logic        den, sweep_done, timeout_err, busy;
   logic [6:0]  daddr;
   logic [3:0]  lee_x, lee_y, king_x, king_y;

   always #5 clk = ~clk;

   xadc_joystick_scheduler #(
      .SAMPLE_BITS(SB), .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .eoc(eoc), .drdy(drdy), .do_data(do_data),
      .den(den), .daddr(daddr), .lee_x(lee_x), .lee_y(lee_y), .king_x(king_x),
      .king_y(king_y), .sweep_done(sweep_done), .timeout_err(timeout_err), .busy(busy)
   );

   typedef struct packed {
      logic [3:0] s0, s1, s2, s3;
      logic       err;
   } exp_t;

   logic [6:0] addr_tab [4] = '{7'h16, 7'h1E, 7'h17, 7'h1F};
   int   checks = 0;
   int   errors = 0;
   int   m_sample [4];
   bit   m_err;
   int   m_slot;
   int   exp_sweeps = 0;
   int   sweep_cnt = 0;
   int   den_cnt = 0;
   int   exp_den = 0;
   exp_t exp_q [$];
   logic [6:0] addr_q [$];
   exp_t e;
   logic den_prev = 1'b0;
   logic busy_prev = 1'b0;
   logic sweep_prev = 1'b0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   function automatic exp_t snap();
      exp_t r;
      r.s0  = 4'(m_sample[0]);
      r.s1  = 4'(m_sample[1]);
      r.s2  = 4'(m_sample[2]);
      r.s3  = 4'(m_sample[3]);
      r.err = m_err;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_sample[i] = 8;
      m_err  = 1'b0;
      m_slot = 0;
   endtask

   // Each den must match the next expected DRP address.
   initial forever begin
      @(negedge clk);
      if (rst_n && den) begin
         den_cnt++;
         if (addr_q.size() == 0) chk("den_unexpected", 1, 0);
         else chk("den_daddr", int'(daddr), int'(addr_q.pop_front()));
         if (den_prev) chk("den_double", 1, 0);
      end
      den_prev = den;
   end

   // End of a transaction (busy falling): all samples and the error flag.
   initial forever begin
      @(negedge clk);
      if (rst_n && busy_prev && !busy) begin
         if (exp_q.size() == 0) chk("txn_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("lee_x", int'(lee_x), int'(e.s0));
            chk("lee_y", int'(lee_y), int'(e.s1));
            chk("king_x", int'(king_x), int'(e.s2));
            chk("king_y", int'(king_y), int'(e.s3));
            chk("timeout_err", int'(timeout_err), int'(e.err));
         end
      end
      busy_prev = busy;
   end

   initial forever begin
      @(negedge clk);
      if (sweep_done) begin
         sweep_cnt++;
         if (sweep_prev) chk("sweep_pulse_width", 2, 1);
      end
      sweep_prev = sweep_done;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic start_txn(output bit got);
      got = 1'b0;
      addr_q.push_back(addr_tab[m_slot]);
      exp_den++;
      @(negedge clk) eoc = 1'b1;
      @(negedge clk) eoc = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
         if (den) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) begin
         chk("den_missing", 0, 1);
         addr_q.delete();
      end
   endtask

   // j: drdy j cycles after den (0 = never; TO = last legal cycle; >TO = too late).
   task automatic txn(input int j, input logic [15:0] data, input bit spur, input bit drop_run);
      bit got;
      int slot;
      slot = m_slot;
      start_txn(got);
      if (!got) return;
      if (drop_run) run = 1'b0;
      if (j >= 1 && j <= TO) m_sample[slot] = int'(data) >> 12;
      else m_err = 1'b1;
      exp_q.push_back(snap());
      if (j == 0) begin
         repeat (TO) @(negedge clk);
         chk("busy_until_expiry", int'(busy), 1);
      end else begin
         repeat (j) @(negedge clk);
         drdy = 1'b1;
         do_data = data;
         @(negedge clk) drdy = 1'b0;
      end
      for (int i = 0; i < TO + 4 && busy; i++) @(negedge clk);
      if (busy) chk("busy_stuck", 1, 0);
      if (spur) begin
         @(negedge clk);
         drdy = 1'b1;
         eoc = 1'b1;
         do_data = 16'h1000;
         @(negedge clk);
         drdy = 1'b0;
         eoc = 1'b0;
      end
      repeat (ST + 3) @(negedge clk);
      m_slot = (slot + 1) % 4;
      if (slot == 3) exp_sweeps++;
   endtask

   initial begin
      int s0, j, r;
      bit got;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_den", int'(den), 0);
      chk("rst_daddr", int'(daddr), 'h16);
      chk("rst_lee_x", int'(lee_x), 8);
      chk("rst_lee_y", int'(lee_y), 8);
      chk("rst_king_x", int'(king_x), 8);
      chk("rst_king_y", int'(king_y), 8);
      chk("rst_sweep_done", int'(sweep_done), 0);
      chk("rst_timeout_err", int'(timeout_err), 0);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      run = 1'b1;
      @(negedge clk);

      s0 = sweep_cnt;
      txn(3, 16'hC000, 0, 0);
      txn(3, 16'h3000, 0, 0);
      txn(3, 16'h8000, 0, 0);
      txn(3, 16'hF000, 0, 0);
      chk("sweep_lee_x", int'(lee_x), 12);
      chk("sweep_lee_y", int'(lee_y), 3);
      chk("sweep_king_x", int'(king_x), 8);
      chk("sweep_king_y", int'(king_y), 15);
      chk("sweep_pulses", sweep_cnt - s0, 1);

      txn(TO, 16'h5000, 0, 0);
      chk("race_sample", int'(lee_x), 5);
      chk("race_no_err", int'(timeout_err), 0);

      txn(0, 16'hEEEE, 0, 0);
      chk("timeout_err_set", int'(timeout_err), 1);
      chk("timeout_keep", int'(lee_y), 3);
      txn(2, 16'h6000, 0, 0);
      chk("after_timeout", int'(king_x), 6);

      txn(1, 16'h2000, 1, 0);
      chk("spurious_sample", int'(king_y), 2);
      chk("spurious_den_count", den_cnt, exp_den);

      txn(2, 16'h9000, 0, 1);
      chk("run0_capture", int'(lee_x), 9);
      repeat (2) begin
         @(negedge clk) eoc = 1'b1;
         @(negedge clk) eoc = 1'b0;
      end
      repeat (10) @(negedge clk);
      chk("parked_no_den", den_cnt, exp_den);
      run = 1'b1;
      repeat (3) @(negedge clk);
      chk("resume_needs_eoc", den_cnt, exp_den);
      txn(3, 16'hA000, 0, 0);
      chk("resume_slot1", int'(lee_y), 10);

      start_txn(got);
      @(negedge clk) rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drdy = 1'b1;
      do_data = 16'hF000;
      @(negedge clk) drdy = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst_lee_x", int'(lee_x), 8);
      chk("midrst_lee_y", int'(lee_y), 8);
      chk("midrst_king_x", int'(king_x), 8);
      chk("midrst_king_y", int'(king_y), 8);
      chk("midrst_daddr", int'(daddr), 'h16);
      chk("midrst_err", int'(timeout_err), 0);
      chk("midrst_busy", int'(busy), 0);

      for (int n = 0; n < 30; n++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      j = 0;
         else if (r == 1) j = TO + 1;
         else if (r == 2) j = TO;
         else             j = int'($urandom_range(1, TO - 1));
         txn(j, 16'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
         run = 1'b1;
      end

      chk("total_sweeps", sweep_cnt, exp_sweeps);
      chk("total_den", den_cnt, exp_den);
      chk("addr_q_drained", addr_q.size(), 0);
      chk("exp_q_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
